// File: rtl/loop_filter_pkg.sv
// Shared types for the geared PI loop filter: mode and error encodings.
// Also holds the saturating clamp used on the integrator and tuning word paths.
// All filter arithmetic runs at CW bits, which covers any TW_WIDTH up to 64 plus sign and carry.
package loop_filter_pkg;

  localparam int CW = 66;

  typedef logic signed [CW-1:0] wide_t;

  typedef enum logic {
    MODE_ACQ = 1'b0,
    MODE_TRK = 1'b1
  } mode_t;

  // Phase error as a signed two-bit value: +1, -1 or 0 (quiet).
  typedef logic signed [1:0] err_t;
  localparam err_t ERR_ZERO = 2'sb00;
  localparam err_t ERR_POS  = 2'sb01;
  localparam err_t ERR_NEG  = 2'sb11;

  function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/loop_lock_detect.sv
// Lock detector: selects ACQ or TRK mode from the recent history of the phase error.
// Enters TRK after LOCK_CYCLES quiet cycles; drops to ACQ after UNLOCK_CYCLES same-sign errors.
// hold freezes the state and both counters.
module loop_lock_detect
  import loop_filter_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES   = 8,
  parameter int unsigned UNLOCK_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  err_t  err,
  input  logic  hold,
  output mode_t mode
);

  localparam int unsigned CNT_MAX = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CYCLES);

  logic [CNT_W-1:0] quiet_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] quiet_inc;
  logic [CNT_W-1:0] run_nxt;
  err_t             last_err;

  // Saturating next values; a run continues only when the sign matches the previous nonzero error.
  always_comb begin
    quiet_inc = (quiet_cnt == '1) ? quiet_cnt : quiet_cnt + 1'b1;
    run_nxt   = CNT_W'(1);
    if (err != ERR_ZERO && err == last_err && run_cnt != '0)
      run_nxt = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
  end

  // Two-state lock FSM with its counters; the threshold edge switches mode and clears both counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= MODE_ACQ;
      quiet_cnt <= '0;
      run_cnt   <= '0;
      last_err  <= ERR_ZERO;
    end else if (!hold) begin
      case (mode)
        MODE_ACQ: begin
          if (err == ERR_ZERO) begin
            if (quiet_inc == LOCK_C) begin
              mode      <= MODE_TRK;
              quiet_cnt <= '0;
              run_cnt   <= '0;
            end else begin
              quiet_cnt <= quiet_inc;
            end
          end else begin
            quiet_cnt <= '0;
          end
        end
        MODE_TRK: begin
          if (err == ERR_ZERO) begin
            run_cnt <= '0;
          end else begin
            last_err <= err;
            if (run_nxt == UNLOCK_C) begin
              mode      <= MODE_ACQ;
              run_cnt   <= '0;
              quiet_cnt <= '0;
            end else begin
              run_cnt <= run_nxt;
            end
          end
        end
        default: mode <= MODE_ACQ;
      endcase
    end
  end

endmodule

// File: rtl/loop_filter_geared.sv
// PI loop filter with acquisition/tracking gain sets, turning PFD up/down into an NCO tuning word.
// One cycle from up/down to tuning_word; integrator and output are clamped to [FREQ_MIN, FREQ_MAX].
// hold freezes the integrator and lock detector and drops the proportional term.
module loop_filter_geared
  import loop_filter_pkg::*;
#(
  parameter int unsigned           TW_WIDTH      = 32,
  parameter logic [TW_WIDTH-1:0]   INITIAL_FREQ  = TW_WIDTH'(1000),
  parameter logic [TW_WIDTH-1:0]   FREQ_MIN      = '0,
  parameter logic [TW_WIDTH-1:0]   FREQ_MAX      = '1,
  parameter int unsigned           KP_ACQ        = 16,
  parameter int unsigned           KI_ACQ        = 4,
  parameter int unsigned           KP_TRK        = 4,
  parameter int unsigned           KI_TRK        = 1,
  parameter int unsigned           LOCK_CYCLES   = 8,
  parameter int unsigned           UNLOCK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up,
  input  logic                down,
  input  logic                hold,
  output logic [TW_WIDTH-1:0] tuning_word,
  output logic                locked,
  output logic                mode
);

  if (TW_WIDTH < 1 || TW_WIDTH > 64 ||
      FREQ_MIN > INITIAL_FREQ || INITIAL_FREQ > FREQ_MAX ||
      KP_ACQ < 1 || KI_ACQ < 1 || KP_TRK < 1 || KI_TRK < 1 ||
      LOCK_CYCLES < 1 || UNLOCK_CYCLES < 1) begin : g_param_check
    $error("loop_filter_geared: illegal parameter set");
  end

  localparam wide_t KP_ACQ_W = wide_t'(KP_ACQ);
  localparam wide_t KI_ACQ_W = wide_t'(KI_ACQ);
  localparam wide_t KP_TRK_W = wide_t'(KP_TRK);
  localparam wide_t KI_TRK_W = wide_t'(KI_TRK);
  localparam wide_t MIN_W    = wide_t'(FREQ_MIN);
  localparam wide_t MAX_W    = wide_t'(FREQ_MAX);

  logic [TW_WIDTH-1:0] integ;
  logic [TW_WIDTH-1:0] integ_nxt;
  logic [TW_WIDTH-1:0] tw_nxt;
  err_t                err;
  mode_t               mode_q;
  wide_t               kp;
  wide_t               ki;
  wide_t               kp_term;
  wide_t               ki_term;
  wide_t               integ_cl;
  wide_t               tw_cl;

  // Map PFD pulses to a signed error; both high counts as quiet.
  always_comb begin
    err = ERR_ZERO;
    if (up && !down)      err = ERR_POS;
    else if (down && !up) err = ERR_NEG;
  end

  loop_lock_detect #(
    .LOCK_CYCLES   (LOCK_CYCLES),
    .UNLOCK_CYCLES (UNLOCK_CYCLES)
  ) u_lock (
    .clk  (clk),
    .rst  (rst),
    .err  (err),
    .hold (hold),
    .mode (mode_q)
  );

  // Gain mux on the registered mode, then clamped integrator and proportional paths.
  always_comb begin
    kp      = (mode_q == MODE_TRK) ? KP_TRK_W : KP_ACQ_W;
    ki      = (mode_q == MODE_TRK) ? KI_TRK_W : KI_ACQ_W;
    kp_term = '0;
    ki_term = '0;
    case (err)
      ERR_POS: begin
        kp_term = kp;
        ki_term = ki;
      end
      ERR_NEG: begin
        kp_term = -kp;
        ki_term = -ki;
      end
      default: ;
    endcase
    integ_cl  = clamp(wide_t'(integ) + ki_term, MIN_W, MAX_W);
    tw_cl     = clamp(integ_cl + kp_term, MIN_W, MAX_W);
    integ_nxt = TW_WIDTH'(integ_cl);
    tw_nxt    = TW_WIDTH'(tw_cl);
  end

  // Integrator and output register; hold presents the bare integrator on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      integ       <= INITIAL_FREQ;
      tuning_word <= INITIAL_FREQ;
    end else if (hold) begin
      tuning_word <= integ;
    end else begin
      integ       <= integ_nxt;
      tuning_word <= tw_nxt;
    end
  end

  assign mode   = mode_q;
  assign locked = (mode_q == MODE_TRK);

endmodule

// File: tb/tb_loop_filter_geared.sv
// Directed bench for loop_filter_geared: a vector table for the default instance, then clamp sequences.
// Extra instances exercise a low FREQ_MAX, a raised FREQ_MIN and full-width saturation.
// All DUTs share the same stimulus.
module tb_loop_filter_geared;

  logic clk = 1'b0;
  logic rst, up, down, hold;

  logic [31:0] tw_dut, tw_max, tw_min, tw_top;
  logic        lk_dut, lk_max, lk_min, lk_top;
  logic        md_dut, md_max, md_min, md_top;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  loop_filter_geared u_dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .hold(hold),
    .tuning_word(tw_dut), .locked(lk_dut), .mode(md_dut)
  );

  loop_filter_geared #(.FREQ_MAX(1050)) u_max (
    .clk(clk), .rst(rst), .up(up), .down(down), .hold(hold),
    .tuning_word(tw_max), .locked(lk_max), .mode(md_max)
  );

  loop_filter_geared #(.FREQ_MIN(990)) u_min (
    .clk(clk), .rst(rst), .up(up), .down(down), .hold(hold),
    .tuning_word(tw_min), .locked(lk_min), .mode(md_min)
  );

  loop_filter_geared #(.INITIAL_FREQ(32'hFFFF_FFF0)) u_top (
    .clk(clk), .rst(rst), .up(up), .down(down), .hold(hold),
    .tuning_word(tw_top), .locked(lk_top), .mode(md_top)
  );

  typedef struct {
    logic        up;
    logic        down;
    logic        hold;
    logic        rst;
    logic [31:0] tw;
    logic        lk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic u, input logic d, input logic h, input logic r,
                     input int unsigned tw, input logic lk);
    vec_t v;
    v.up = u; v.down = d; v.hold = h; v.rst = r; v.tw = tw; v.lk = lk;
    vecs.push_back(v);
  endtask

  task automatic step(input logic u, input logic d, input logic h, input logic r);
    up = u; down = d; hold = h; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  longint im, it, e, et;
  localparam longint MAXU = 64'hFFFF_FFFF;

  initial begin
    up = 1'b0; down = 1'b0; hold = 1'b0; rst = 1'b1;

    // Reset, then ten up cycles in ACQ (KI=4, KP=16).
    add(0, 0, 0, 1, 1000, 0);
    for (int k = 1; k <= 10; k++) add(1, 0, 0, 0, 1000 + 4 * k + 16, 0);
    // Eight quiet cycles in total: kick drops to integ, lock on the eighth.
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 1040, 0);
    add(0, 0, 0, 0, 1040, 1);
    // One up in TRK (KI=1, KP=4), then quiet.
    add(1, 0, 0, 0, 1045, 1);
    add(0, 0, 0, 0, 1041, 1);
    // Down run: unlock on the fourth, fifth uses ACQ gains.
    add(0, 1, 0, 0, 1036, 1);
    add(0, 1, 0, 0, 1035, 1);
    add(0, 1, 0, 0, 1034, 1);
    add(0, 1, 0, 0, 1033, 0);
    add(0, 1, 0, 0, 1017, 0);
    // Relock, then alternating signs must not unlock.
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 1033, 0);
    add(0, 0, 0, 0, 1033, 1);
    for (int k = 0; k < 3; k++) begin
      add(1, 0, 0, 0, 1038, 1);
      add(0, 1, 0, 0, 1029, 1);
    end
    add(0, 0, 0, 0, 1033, 1);
    // Reset mid-run with every other input active.
    add(1, 1, 1, 1, 1000, 0);
    // Both pulses high count as quiet.
    for (int k = 1; k <= 7; k++) add(1, 1, 0, 0, 1000, 0);
    add(1, 1, 0, 0, 1000, 1);
    // Three downs in TRK, hold with up, then one more down completes the unlock run.
    add(0, 1, 0, 0, 995, 1);
    add(0, 1, 0, 0, 994, 1);
    add(0, 1, 0, 0, 993, 1);
    for (int k = 0; k < 5; k++) add(1, 0, 1, 0, 997, 1);
    add(0, 1, 0, 0, 992, 0);
    // Reset wins over hold.
    add(1, 0, 1, 1, 1000, 0);

    foreach (vecs[i]) begin
      step(vecs[i].up, vecs[i].down, vecs[i].hold, vecs[i].rst);
      check("tuning_word", i, {32'd0, tw_dut}, {32'd0, vecs[i].tw});
      check("locked", i, {63'd0, lk_dut}, {63'd0, vecs[i].lk});
      check("mode", i, {63'd0, md_dut}, {63'd0, vecs[i].lk});
    end

    // Ceiling: FREQ_MAX=1050 instance and full-width instance near 2^32-1.
    step(0, 0, 0, 1);
    check("max_reset", 0, {32'd0, tw_max}, 64'd1000);
    check("top_reset", 0, {32'd0, tw_top}, 64'hFFFF_FFF0);
    im = 1000;
    it = 64'hFFFF_FFF0;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 0, 0);
      im = (im + 4 > 1050) ? 1050 : im + 4;
      e  = (im + 16 > 1050) ? 1050 : im + 16;
      it = (it + 4 > MAXU) ? MAXU : it + 4;
      et = (it + 16 > MAXU) ? MAXU : it + 16;
      check("max_clamp", k, {32'd0, tw_max}, e);
      check("top_clamp", k, {32'd0, tw_top}, et);
    end
    step(0, 0, 0, 0);
    check("max_settle", 0, {32'd0, tw_max}, 64'd1050);

    // Floor: FREQ_MIN=990 instance.
    step(0, 0, 0, 1);
    check("min_reset", 0, {32'd0, tw_min}, 64'd1000);
    im = 1000;
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 0, 0);
      im = (im - 4 < 990) ? 990 : im - 4;
      e  = (im - 16 < 990) ? 990 : im - 16;
      check("min_clamp", k, {32'd0, tw_min}, e);
    end
    step(0, 0, 0, 0);
    check("min_settle", 0, {32'd0, tw_min}, 64'd990);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
